lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Parametrised load/store unit for the multi-cycle core's memory stage. Replaces the combinational DPI memory access with a valid/ready request/response handshake and a generic request/grant/response data bus. Adds byte-lane strobes, alignment checking, an XLEN-wide datapath and a bus timeout. The response handshake serves as the stage's commit signal.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64.
ADDR_W, 32, address width.
TIMEOUT_CYC, 256, maximum number of cycles spent in REQ+WAIT; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset, synchronous, active-low.
in_valid  in  1  request valid from execute.
in_ready  out  1  unit can accept a request.
in_op  in  4  bit3 = store; bits[2:0] are funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
in_addr  in  ADDR_W  byte address (valE).
in_wdata  in  XLEN  store data (regB), right-justified.
out_valid  out  1  response valid (commit).
out_ready  in  1  downstream accepts the response.
out_rdata  out  XLEN  load result, sign- or zero-extended; 0 for stores and errors.
out_err  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal op.
bus_req  out  1  bus request.
bus_we  out  1  write request.
bus_addr  out  ADDR_W  XLEN/8-aligned address.
bus_wdata  out  XLEN  lane-shifted write data.
bus_wstrb  out  XLEN/8  byte enables; 0 for reads.
bus_gnt  in  1  request accepted; valid only while bus_req=1.
bus_rvalid  in  1  read data valid or write ack; valid no earlier than the cycle after gnt.
bus_rdata  in  XLEN  read data.

Behaviour:
- Reset (rst=0 at an edge): state goes to IDLE. All outputs are 0 except in_ready=1. Timeout counter is cleared. An in-flight bus_req drops at that edge, with no response generated.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid, latch op, addr and wdata, and decode at the accept edge.
  - Illegal op goes to RESP with err=3. Illegal ops are: store with bit2=1; funct3=111; 'd' or 'wu' when XLEN=32.
  - Misaligned access goes to RESP with err=1. Misaligned means addr mod size ≠ 0, with size 1/2/4/8.
  - Otherwise go to REQ.
  - Any error response therefore appears 1 cycle after accept.
- REQ: bus_req=1; bus_we, bus_addr, bus_wdata and bus_wstrb are registered and held stable until gnt. On bus_gnt, go to WAIT and deassert bus_req on the next cycle. bus_rvalid is ignored in REQ.
- WAIT: on bus_rvalid, go to RESP.
  - Load: capture out_rdata = extend(bus_rdata >> (lane*8)), where lane = addr[log2(XLEN/8)-1:0].
  - Store: capture out_rdata = 0, err=0.
- Write formatting:
  - bus_wstrb = ((1<<size)-1) << lane.
  - bus_wdata = in_wdata << (lane*8); bytes outside the strobe are don't-care.
- Timeout: the counter increments every cycle in REQ or WAIT.
  - When the counter reaches TIMEOUT_CYC-1 with no completing event, go to RESP with err=2, out_rdata=0, and drop bus_req.
  - If rvalid (or gnt in REQ) arrives in the same cycle as expiry, the bus event wins.
  - A bus_rvalid arriving after a timeout, in IDLE or RESP, is ignored.
  - The counter clears on entering REQ.
- RESP: out_valid=1; out_rdata and out_err are held stable until out_ready. On out_valid&out_ready, go to IDLE. in_ready=0 in REQ, WAIT and RESP.
- Throughput: minimum load/store latency from accept edge to out_valid is 3 cycles (gnt on the first REQ cycle, rvalid on the next). At most one transaction is outstanding.
- Extension rules:
  - b, h and w sign-extend to XLEN; bu, hu and wu zero-extend.
  - 'w' on XLEN=32 is a pass-through.

Test Plan:
1. XLEN=32, lw, addr 0x80000008, gnt immediate, rvalid the next cycle with rdata 0xDEADBEEF -> bus_addr 0x80000008, wstrb 0; out_valid 3 cycles after accept; out_rdata 0xDEADBEEF; err 0.
2. lb then lbu at addr 0x80000003, rdata 0x80112233 -> lb gives 0xFFFFFF80; lbu gives 0x00000080.
3. sh at addr 0x80000002, wdata 0x0000ABCD, gnt delayed 2 cycles -> bus_req held 3 cycles with stable signals; wstrb 4'b1100; wdata[31:16]=0xABCD; bus_we=1; after ack, out_valid with rdata 0.
4. lw at addr 0x80000002 -> no bus_req; out_valid 1 cycle after accept with err=1. sd on XLEN=32 -> err=3.
5. TIMEOUT_CYC=4, gnt never asserted -> bus_req high 4 cycles then low; out_err=2; a later rvalid is ignored; next request proceeds normally.
6. out_ready held 0 for 5 cycles in RESP -> out_valid and data stable, in_ready=0. Separately, rst=0 while in WAIT -> all outputs 0 and in_ready=1 after that edge; no out_valid appears.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit for the memory stage: valid/ready request and response,
// request/grant/response data bus with byte strobes, alignment check and timeout.
module lsu_mem_ctrl #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_rdata,
  output logic [1:0]          out_err,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN-1:0]     bus_wdata,
  output logic [XLEN/8-1:0]   bus_wstrb,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [XLEN-1:0]     bus_rdata
);

  localparam int SW      = XLEN / 8;
  localparam int LW      = $clog2(SW);
  localparam int CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_rdata;
  logic [1:0]        r_out_err;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [XLEN-1:0]   r_bus_wdata;
  logic [SW-1:0]     r_bus_wstrb;
  logic [2:0]        r_f3;
  logic              r_store;
  logic [LW-1:0]     r_lane;
  logic [CW-1:0]     r_cnt;

  logic [2:0]        w_f3;
  logic              w_store;
  logic              w_illegal;
  logic              w_misalign;
  logic [2:0]        w_amask;
  logic [LW-1:0]     w_lane;
  logic [SW-1:0]     w_mask;
  logic [SW-1:0]     w_strb;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rsh;
  logic [XLEN-1:0]   w_ld;
  logic              w_expire;

  // Request decode, evaluated on the live inputs at the accept edge.
  always_comb begin
    w_f3      = in_op[2:0];
    w_store   = in_op[3];
    w_lane    = in_addr[LW-1:0];
    w_illegal = (w_store && w_f3[2]) || (w_f3 == 3'b111) ||
                ((XLEN == 32) && ((w_f3 == 3'b011) || (w_f3 == 3'b110)));
    case (w_f3[1:0])
      2'd0:    begin w_mask = SW'(8'h01); w_amask = 3'b000; end
      2'd1:    begin w_mask = SW'(8'h03); w_amask = 3'b001; end
      2'd2:    begin w_mask = SW'(8'h0F); w_amask = 3'b011; end
      default: begin w_mask = SW'(8'hFF); w_amask = 3'b111; end
    endcase
    w_misalign = (in_addr[2:0] & w_amask) != 3'b000;
    w_strb     = w_mask << w_lane;
    w_wdata    = in_wdata << {w_lane, 3'b000};
  end

  always_comb begin
    w_rsh = bus_rdata >> {r_lane, 3'b000};
    case (r_f3)
      3'b000:  w_ld = XLEN'($signed(w_rsh[7:0]));
      3'b001:  w_ld = XLEN'($signed(w_rsh[15:0]));
      3'b010:  w_ld = XLEN'($signed(w_rsh[31:0]));
      3'b100:  w_ld = XLEN'(w_rsh[7:0]);
      3'b101:  w_ld = XLEN'(w_rsh[15:0]);
      3'b110:  w_ld = XLEN'(w_rsh[31:0]);
      default: w_ld = w_rsh;
    endcase
    w_expire = (TIMEOUT_CYC != 0) && (r_cnt == CW'(TO_LAST));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_rdata <= '0;
      r_out_err   <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_f3        <= '0;
      r_store     <= 1'b0;
      r_lane      <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_f3       <= w_f3;
            r_store    <= w_store;
            r_lane     <= w_lane;
            r_cnt      <= '0;
            if (w_illegal) begin
              r_state     <= S_RESP;
              r_out_valid <= 1'b1;
              r_out_err   <= 2'd3;
              r_out_rdata <= '0;
            end else if (w_misalign) begin
              r_state     <= S_RESP;
              r_out_valid <= 1'b1;
              r_out_err   <= 2'd1;
              r_out_rdata <= '0;
            end else begin
              r_state     <= S_REQ;
              r_bus_req   <= 1'b1;
              r_bus_we    <= w_store;
              r_bus_addr  <= {in_addr[ADDR_W-1:LW], {LW{1'b0}}};
              r_bus_wdata <= w_store ? w_wdata : '0;
              r_bus_wstrb <= w_store ? w_strb : '0;
            end
          end
        end
        // Grant takes priority over an expiry in the same cycle.
        S_REQ: begin
          r_cnt <= r_cnt + CW'(1);
          if (bus_gnt || w_expire) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
          end
          if (bus_gnt) begin
            r_state <= S_WAIT;
          end else if (w_expire) begin
            r_state     <= S_RESP;
            r_out_valid <= 1'b1;
            r_out_err   <= 2'd2;
            r_out_rdata <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (bus_rvalid) begin
            r_state     <= S_RESP;
            r_out_valid <= 1'b1;
            r_out_err   <= 2'd0;
            r_out_rdata <= r_store ? '0 : w_ld;
          end else if (w_expire) begin
            r_state     <= S_RESP;
            r_out_valid <= 1'b1;
            r_out_err   <= 2'd2;
            r_out_rdata <= '0;
          end
        end
        default: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_rdata <= '0;
            r_out_err   <= '0;
            r_in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_rdata = r_out_rdata;
  assign out_err   = r_out_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wstrb = r_bus_wstrb;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl (XLEN=32, TIMEOUT_CYC=4): responses are checked
// against a scoreboard queue filled when each request is driven.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  logic [33:0] sb_q[$];
  logic [33:0] sb_e;

  localparam logic [3:0] OP_LB  = 4'b0000, OP_LH  = 4'b0001, OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100, OP_LHU = 4'b0101, OP_LWU = 4'b0110;
  localparam logic [3:0] OP_SB  = 4'b1000, OP_SH  = 4'b1001, OP_SW  = 4'b1010;
  localparam logic [3:0] OP_SD  = 4'b1011, OP_BADS = 4'b1100, OP_F7 = 4'b0111;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] smask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  // Response monitor: pops the scoreboard on every completed response handshake.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        chk("resp_rdata", 64'(out_rdata), 64'(sb_e[33:2]));
        chk("resp_err", 64'(out_err), 64'(sb_e[1:0]));
      end
    end
  end

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input bit push, input logic [31:0] e_rd, input logic [1:0] e_err);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    in_wdata = wd;
    if (push) sb_q.push_back({e_rd, e_err});
    tick();
    in_valid = 1'b0;
    in_op    = '0;
    in_addr  = '0;
    in_wdata = '0;
  endtask

  // Bus slave: grant after gnt_dly extra REQ cycles (stray rvalid meanwhile), ack next cycle.
  task automatic bus_xact(input int gnt_dly, input logic [31:0] rd, input logic [31:0] e_addr,
                          input logic e_we, input logic [3:0] e_strb, input logic [31:0] e_wd);
    for (int i = 0; i <= gnt_dly; i++) begin
      chk("bus_req", 64'(bus_req), 64'd1);
      chk("bus_addr", 64'(bus_addr), 64'(e_addr));
      chk("bus_we", 64'(bus_we), 64'(e_we));
      chk("bus_wstrb", 64'(bus_wstrb), 64'(e_strb));
      chk("bus_wdata", 64'(bus_wdata & smask(e_strb)), 64'(e_wd));
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      chk("no_early_resp", 64'(out_valid), 64'd0);
      bus_gnt    = (i == gnt_dly);
      bus_rvalid = (i < gnt_dly);
      tick();
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    chk("req_drop", 64'(bus_req), 64'd0);
    chk("no_resp_wait", 64'(out_valid), 64'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = rd;
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    chk("resp_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic err_req(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [1:0] e_err);
    do_req(op, addr, 32'h1234_5678, 1'b1, 32'h0, e_err);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_noreq"}, 64'(bus_req), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0;
    out_ready = 1'b1; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_out_rdata", 64'(out_rdata), 64'd0);
    rst = 1'b1;
    tick();

    // Loads with sign and zero extension
    do_req(OP_LW, 32'h8000_0008, '0, 1'b1, 32'hDEAD_BEEF, 2'd0);
    bus_xact(0, 32'hDEAD_BEEF, 32'h8000_0008, 1'b0, 4'b0000, 32'h0);
    tick();
    do_req(OP_LB, 32'h8000_0003, '0, 1'b1, 32'hFFFF_FF80, 2'd0);
    bus_xact(0, 32'h8011_2233, 32'h8000_0000, 1'b0, 4'b0000, 32'h0);
    tick();
    do_req(OP_LBU, 32'h8000_0003, '0, 1'b1, 32'h0000_0080, 2'd0);
    bus_xact(1, 32'h8011_2233, 32'h8000_0000, 1'b0, 4'b0000, 32'h0);
    tick();
    do_req(OP_LH, 32'h8000_0002, '0, 1'b1, 32'hFFFF_8011, 2'd0);
    bus_xact(0, 32'h8011_2233, 32'h8000_0000, 1'b0, 4'b0000, 32'h0);
    tick();
    do_req(OP_LHU, 32'h8000_0002, '0, 1'b1, 32'h0000_8011, 2'd0);
    bus_xact(0, 32'h8011_2233, 32'h8000_0000, 1'b0, 4'b0000, 32'h0);
    tick();

    // Stores: gnt delay 2 puts the ack on the expiry cycle, the ack must win
    do_req(OP_SH, 32'h8000_0002, 32'h0000_ABCD, 1'b1, 32'h0, 2'd0);
    bus_xact(2, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 4'b1100, 32'hABCD_0000);
    tick();
    do_req(OP_SB, 32'h8000_0001, 32'h0000_00A5, 1'b1, 32'h0, 2'd0);
    bus_xact(0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 4'b0010, 32'h0000_A500);
    tick();
    do_req(OP_SW, 32'h8000_0004, 32'h1234_5678, 1'b1, 32'h0, 2'd0);
    bus_xact(1, 32'hFFFF_FFFF, 32'h8000_0004, 1'b1, 4'b1111, 32'h1234_5678);
    tick();

    // Misaligned and illegal requests
    err_req("mis_lw", OP_LW, 32'h8000_0002, 2'd1);
    err_req("mis_sh", OP_SH, 32'h8000_0001, 2'd1);
    err_req("ill_sd", OP_SD, 32'h8000_0000, 2'd3);
    err_req("ill_bads", OP_BADS, 32'h8000_0000, 2'd3);
    err_req("ill_f7", OP_F7, 32'h8000_0000, 2'd3);
    err_req("ill_lwu", OP_LWU, 32'h8000_0000, 2'd3);

    // Timeout with no grant, then stale rvalid in RESP and in IDLE
    do_req(OP_LW, 32'h8000_0010, '0, 1'b1, 32'h0, 2'd2);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_high", 64'(bus_req), 64'd1);
      chk("to_no_resp", 64'(out_valid), 64'd0);
      tick();
    end
    chk("to_req_low", 64'(bus_req), 64'd0);
    chk("to_resp", 64'(out_valid), 64'd1);
    out_ready  = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h5555_5555;
    tick();
    chk("to_stale_rdata", 64'(out_rdata), 64'd0);
    chk("to_stale_err", 64'(out_err), 64'd2);
    bus_rvalid = 1'b0;
    out_ready  = 1'b1;
    tick();
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    chk("idle_stale_valid", 64'(out_valid), 64'd0);
    chk("idle_stale_req", 64'(bus_req), 64'd0);
    do_req(OP_LW, 32'h8000_0014, '0, 1'b1, 32'h0BAD_F00D, 2'd0);
    bus_xact(0, 32'h0BAD_F00D, 32'h8000_0014, 1'b0, 4'b0000, 32'h0);
    tick();

    // Backpressure on the response
    out_ready = 1'b0;
    do_req(OP_LW, 32'h8000_0030, '0, 1'b1, 32'hCAFE_F00D, 2'd0);
    bus_xact(0, 32'hCAFE_F00D, 32'h8000_0030, 1'b0, 4'b0000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_rdata", 64'(out_rdata), 64'hCAFE_F00D);
      chk("hold_err", 64'(out_err), 64'd0);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("post_hold_ready", 64'(in_ready), 64'd1);

    // Reset while waiting for the bus response
    do_req(OP_LW, 32'h8000_0020, '0, 1'b0, 32'h0, 2'd0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt    = 1'b0;
    rst        = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h7777_7777;
    tick();
    chk("wrst_in_ready", 64'(in_ready), 64'd1);
    chk("wrst_out_valid", 64'(out_valid), 64'd0);
    chk("wrst_bus_req", 64'(bus_req), 64'd0);
    chk("wrst_out_rdata", 64'(out_rdata), 64'd0);
    chk("wrst_out_err", 64'(out_err), 64'd0);
    rst        = 1'b1;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wrst_no_resp", 64'(out_valid), 64'd0);
    end
    do_req(OP_LBU, 32'h8000_0001, '0, 1'b1, 32'h0000_0022, 2'd0);
    bus_xact(0, 32'h8011_2233, 32'h8000_0000, 1'b0, 4'b0000, 32'h0);
    tick();

    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
